// File: rtl/output_port_arbiter_if.sv
// rtl/output_port_arbiter_if.sv - input-FIFO read side and output-FIFO write side of one output port
interface output_port_arbiter_if #(
  parameter int NUM_IN     = 5,
  parameter int DATA_WIDTH = 18
);

  logic [NUM_IN-1:0]            req;
  logic [NUM_IN-1:0]            in_empty;
  logic [NUM_IN*DATA_WIDTH-1:0] in_rd_data;
  logic [NUM_IN-1:0]            in_rd_en;
  logic                         out_full;
  logic                         out_wr_en;
  logic [DATA_WIDTH-1:0]        out_wr_data;
  logic [NUM_IN-1:0]            grant;
  logic                         busy;
  logic                         proto_err;

  modport master (
    input  req, in_empty, in_rd_data, out_full,
    output in_rd_en, out_wr_en, out_wr_data, grant, busy, proto_err
  );

  modport slave (
    output req, in_empty, in_rd_data, out_full,
    input  in_rd_en, out_wr_en, out_wr_data, grant, busy, proto_err
  );

endinterface

// File: rtl/output_port_arbiter.sv
// rtl/output_port_arbiter.sv - packet-granular round-robin arbiter sharing one router output port
module output_port_arbiter #(
  parameter int NUM_IN     = 5,
  parameter int DATA_WIDTH = 18
) (
  input  logic                  clk,
  input  logic                  rst,
  output_port_arbiter_if.master bus
);

  localparam int IDX_W = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_WAIT
  } state_t;

  state_t                state;
  logic [IDX_W-1:0]      rr_ptr;
  logic [IDX_W-1:0]      grant_idx;
  logic [NUM_IN-1:0]     grant_q;
  logic                  busy_q;
  logic                  first_flit;

  logic [NUM_IN-1:0]     elig;
  logic                  pick_found;
  logic [IDX_W-1:0]      pick_idx;
  logic [IDX_W:0]        cand;
  logic [DATA_WIDTH-1:0] flit;
  logic                  flit_head;
  logic                  flit_tail;
  logic                  rd_ok;

  assign elig = bus.req & ~bus.in_empty;

  // Scan starts one past the previous owner, which therefore drops to lowest priority.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int k = 1; k <= NUM_IN; k++) begin
      cand = {1'b0, rr_ptr} + (IDX_W+1)'(k);
      if (cand >= (IDX_W+1)'(NUM_IN)) begin
        cand = cand - (IDX_W+1)'(NUM_IN);
      end
      if (!pick_found && elig[cand[IDX_W-1:0]]) begin
        pick_found = 1'b1;
        pick_idx   = cand[IDX_W-1:0];
      end
    end
  end

  always_comb begin
    flit = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (grant_q[i]) begin
        flit = bus.in_rd_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign flit_head = flit[DATA_WIDTH-1];
  assign flit_tail = flit[DATA_WIDTH-2];

  // Full is only checked here: a read issued now is the only write one cycle later.
  assign rd_ok = (state == S_READ) && ((grant_q & ~bus.in_empty) != '0) && !bus.out_full;

  assign bus.in_rd_en    = rd_ok ? grant_q : '0;
  assign bus.out_wr_en   = (state == S_WAIT);
  assign bus.out_wr_data = (state == S_WAIT) ? flit : '0;
  assign bus.grant       = grant_q;
  assign bus.busy        = busy_q;
  assign bus.proto_err   = (state == S_WAIT) && (first_flit ? !flit_head : flit_head);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      rr_ptr     <= IDX_W'(NUM_IN - 1);
      grant_idx  <= '0;
      grant_q    <= '0;
      busy_q     <= 1'b0;
      first_flit <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (pick_found) begin
            grant_q    <= NUM_IN'(1) << pick_idx;
            grant_idx  <= pick_idx;
            busy_q     <= 1'b1;
            first_flit <= 1'b1;
            state      <= S_READ;
          end
        end
        S_READ: begin
          if (rd_ok) begin
            state <= S_WAIT;
          end
        end
        S_WAIT: begin
          first_flit <= 1'b0;
          if (flit_tail) begin
            grant_q <= '0;
            busy_q  <= 1'b0;
            rr_ptr  <= grant_idx;
            state   <= S_IDLE;
          end else begin
            state <= S_READ;
          end
        end
        default: begin
          state   <= S_IDLE;
          grant_q <= '0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_output_port_arbiter.sv
// tb/tb_output_port_arbiter.sv - randomized and directed bench for output_port_arbiter
module tb_output_port_arbiter;

  localparam int N  = 5;
  localparam int DW = 18;

  logic clk = 1'b0;
  logic rst;

  output_port_arbiter_if #(.NUM_IN(N), .DATA_WIDTH(DW)) bus ();

  output_port_arbiter #(.NUM_IN(N), .DATA_WIDTH(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] fq [N][$];
  int            plen [N][$];
  logic [DW-1:0] rdr [N];
  logic [N-1:0]  req_mask;

  logic [DW-1:0] got [$];
  int            got_cyc [$];
  int            gseen [$];
  int            proto_cnt, viol, mcyc;
  logic [DW-1:0] exp_flits [$];
  int            exp_grants [$];

  logic [N-1:0]  s_rd, s_grant;
  logic [N-1:0]  prev_grant = '0;
  logic          s_wr, s_busy, s_perr;
  logic [DW-1:0] s_wdata;

  int tests = 0;
  int fails = 0;

  function automatic logic [DW-1:0] mk(input logic h, input logic t, input logic [DW-3:0] p);
    return {h, t, p};
  endfunction

  function automatic int idx_of(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic refresh();
    for (int i = 0; i < N; i++) begin
      bus.in_empty[i]             = (fq[i].size() == 0);
      bus.in_rd_data[i*DW +: DW]  = rdr[i];
    end
  endtask

  // Sample at the falling edge; the input FIFOs pop just after the rising edge (registered rd_data).
  task automatic tick();
    logic [N-1:0] rd;
    @(negedge clk);
    mcyc++;
    s_rd = bus.in_rd_en; s_wr = bus.out_wr_en; s_wdata = bus.out_wr_data;
    s_grant = bus.grant; s_busy = bus.busy; s_perr = bus.proto_err;
    rd = s_rd;
    if (s_wr === 1'b1) begin got.push_back(s_wdata); got_cyc.push_back(mcyc); end
    if (s_perr === 1'b1) proto_cnt++;
    if (s_grant != '0 && prev_grant == '0) gseen.push_back(idx_of(s_grant));
    if (((s_rd & ~s_grant) != '0) || ($countones(s_grant) > 1) || (s_busy != (s_grant != '0))) viol++;
    prev_grant = s_grant;
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (rd[i] === 1'b1) begin
        if (fq[i].size() == 0) viol++;
        else rdr[i] = fq[i].pop_front();
      end
    end
    refresh();
  endtask

  task automatic clear_mon();
    got.delete(); got_cyc.delete(); gseen.delete();
    proto_cnt = 0; viol = 0; mcyc = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.req = '0;
    bus.out_full = 1'b0;
    for (int i = 0; i < N; i++) begin
      fq[i].delete(); plen[i].delete(); rdr[i] = '0;
    end
    refresh();
    repeat (2) tick();
    rst = 1'b0;
    clear_mon();
  endtask

  task automatic load_pkt(input int i, input int len);
    for (int k = 0; k < len; k++) fq[i].push_back(mk(k == 0, k == len - 1, (DW-2)'($urandom)));
    plen[i].push_back(len);
    refresh();
  endtask

  // Reference: whole packets served in round-robin order starting after input N-1.
  task automatic build_expected();
    logic [DW-1:0] cq [N][$];
    int cl [N][$];
    int ptr, sel, n;
    exp_flits.delete(); exp_grants.delete();
    for (int i = 0; i < N; i++) begin cq[i] = fq[i]; cl[i] = plen[i]; end
    ptr = N - 1;
    forever begin
      sel = -1;
      for (int k = 1; k <= N; k++) begin
        if (sel < 0 && req_mask[(ptr + k) % N] && cl[(ptr + k) % N].size() > 0) sel = (ptr + k) % N;
      end
      if (sel < 0) break;
      n = cl[sel].pop_front();
      repeat (n) exp_flits.push_back(cq[sel].pop_front());
      exp_grants.push_back(sel);
      ptr = sel;
    end
  endtask

  task automatic run_collect(input int full_pct, output bit timed_out);
    int budget;
    budget = 12 * exp_flits.size() + 40;
    bus.req = req_mask;
    timed_out = 1'b0;
    while (got.size() < exp_flits.size()) begin
      if (mcyc >= budget) begin timed_out = 1'b1; break; end
      bus.out_full = (full_pct > 0) && (int'($urandom_range(0, 99)) < full_pct);
      tick();
    end
    bus.out_full = 1'b0;
    repeat (4) tick();
  endtask

  task automatic test_reset();
    do_reset();
    load_pkt(0, 1); load_pkt(3, 2);
    bus.req = 5'b11111;
    rst = 1'b1;
    repeat (2) tick();
    tests++; if (s_grant !== 5'b0) begin fails++; $display("FAIL reset_grant got=%b exp=00000", s_grant); end
    tests++; if (s_rd !== 5'b0) begin fails++; $display("FAIL reset_rd_en got=%b exp=00000", s_rd); end
    tests++; if (s_wr !== 1'b0) begin fails++; $display("FAIL reset_wr_en got=%b exp=0", s_wr); end
    tests++; if (s_wdata !== '0) begin fails++; $display("FAIL reset_wr_data got=%h exp=0", s_wdata); end
    tests++; if (s_busy !== 1'b0) begin fails++; $display("FAIL reset_busy got=%b exp=0", s_busy); end
    tests++; if (s_perr !== 1'b0) begin fails++; $display("FAIL reset_proto_err got=%b exp=0", s_perr); end
    rst = 1'b0;
    clear_mon();
    tick();
    tests++; if (s_grant !== 5'b0 || s_rd !== 5'b0) begin fails++; $display("FAIL idle_cycle grant=%b rd=%b exp=00000/00000", s_grant, s_rd); end
    tick();
    tests++; if (s_grant !== 5'b00001) begin fails++; $display("FAIL first_priority got=%b exp=00001", s_grant); end
  endtask

  task automatic test_single_packet();
    logic [DW-1:0] f [3];
    logic [N-1:0] exp_rd, exp_g;
    do_reset();
    f[0] = mk(1'b1, 1'b0, 16'h0A01); f[1] = mk(1'b0, 1'b0, 16'h0A02); f[2] = mk(1'b0, 1'b1, 16'h0A03);
    for (int k = 0; k < 3; k++) fq[0].push_back(f[k]);
    refresh();
    bus.req = 5'b00001;
    for (int c = 1; c <= 8; c++) begin
      tick();
      exp_rd = (c == 2 || c == 4 || c == 6) ? 5'b00001 : 5'b00000;
      exp_g  = (c >= 2 && c <= 7) ? 5'b00001 : 5'b00000;
      tests++; if (s_rd !== exp_rd) begin fails++; $display("FAIL single_rd c=%0d got=%b exp=%b", c, s_rd, exp_rd); end
      tests++; if (s_grant !== exp_g) begin fails++; $display("FAIL single_grant c=%0d got=%b exp=%b", c, s_grant, exp_g); end
      tests++; if (s_wr !== (c == 3 || c == 5 || c == 7)) begin fails++; $display("FAIL single_wr c=%0d got=%b", c, s_wr); end
      if (c == 3 || c == 5 || c == 7) begin
        tests++; if (s_wdata !== f[(c - 3) / 2]) begin fails++; $display("FAIL single_data c=%0d got=%h exp=%h", c, s_wdata, f[(c - 3) / 2]); end
      end
    end
  endtask

  task automatic test_round_robin_all();
    bit to;
    do_reset();
    for (int i = 0; i < N; i++) load_pkt(i, 1);
    req_mask = 5'b11111;
    build_expected();
    run_collect(0, to);
    tests++; if (to) begin fails++; $display("FAIL rr_timeout got=%0d flits exp=%0d", got.size(), exp_flits.size()); end
    tests++; if (got.size() != 5) begin fails++; $display("FAIL rr_count got=%0d exp=5", got.size()); end
    for (int k = 0; k < got.size() && k < exp_flits.size(); k++) begin
      tests++; if (got[k] !== exp_flits[k]) begin fails++; $display("FAIL rr_data k=%0d got=%h exp=%h", k, got[k], exp_flits[k]); end
      tests++; if (got_cyc[k] != 3 * (k + 1)) begin fails++; $display("FAIL rr_cycle k=%0d got=%0d exp=%0d", k, got_cyc[k], 3 * (k + 1)); end
    end
    for (int k = 0; k < 5; k++) begin
      tests++; if (k >= gseen.size() || gseen[k] != k) begin fails++; $display("FAIL rr_order k=%0d seen=%0d exp=%0d", k, (k < gseen.size()) ? gseen[k] : -1, k); end
    end
  endtask

  task automatic test_back_to_back();
    bit to;
    int order [4];
    order = '{1, 3, 1, 3};
    do_reset();
    load_pkt(1, 2); load_pkt(1, 2); load_pkt(3, 2); load_pkt(3, 2);
    req_mask = 5'b01010;
    build_expected();
    run_collect(0, to);
    tests++; if (to || got.size() != 8) begin fails++; $display("FAIL b2b_count got=%0d exp=8", got.size()); end
    for (int k = 0; k < got.size() && k < exp_flits.size(); k++) begin
      tests++; if (got[k] !== exp_flits[k]) begin fails++; $display("FAIL b2b_data k=%0d got=%h exp=%h", k, got[k], exp_flits[k]); end
    end
    for (int k = 0; k < 4; k++) begin
      tests++; if (k >= gseen.size() || gseen[k] != order[k]) begin fails++; $display("FAIL b2b_order k=%0d seen=%0d exp=%0d", k, (k < gseen.size()) ? gseen[k] : -1, order[k]); end
    end
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] snap [$];
    int wc [3];
    wc = '{3, 9, 11};
    do_reset();
    load_pkt(0, 3);
    snap = fq[0];
    bus.req = 5'b00001;
    for (int c = 1; c <= 14; c++) begin
      bus.out_full = (c >= 4 && c <= 7);
      tick();
      if (c >= 4 && c <= 7) begin
        tests++; if (s_rd !== 5'b0) begin fails++; $display("FAIL bp_rd_while_full c=%0d got=%b exp=00000", c, s_rd); end
      end
      if (c == 8) begin
        tests++; if (s_rd !== 5'b00001) begin fails++; $display("FAIL bp_resume got=%b exp=00001", s_rd); end
      end
    end
    bus.out_full = 1'b0;
    tests++; if (got.size() != 3) begin fails++; $display("FAIL bp_count got=%0d exp=3", got.size()); end
    for (int k = 0; k < got.size() && k < 3; k++) begin
      tests++; if (got[k] !== snap[k] || got_cyc[k] != wc[k]) begin fails++; $display("FAIL bp_flit k=%0d got=%h@%0d exp=%h@%0d", k, got[k], got_cyc[k], snap[k], wc[k]); end
    end
    tests++; if (viol != 0) begin fails++; $display("FAIL bp_violations got=%0d exp=0", viol); end
  endtask

  task automatic test_empty_stall();
    logic [DW-1:0] e [4];
    e = '{mk(1'b1, 1'b0, 16'h2001), mk(1'b0, 1'b0, 16'h2002), mk(1'b0, 1'b1, 16'h2003), mk(1'b1, 1'b1, 16'h0001)};
    do_reset();
    fq[2].push_back(e[0]);
    refresh();
    bus.req = 5'b00100;
    for (int c = 1; c <= 18; c++) begin
      if (c == 3) begin fq[0].push_back(e[3]); bus.req = 5'b00101; refresh(); end
      if (c == 10) begin fq[2].push_back(e[1]); fq[2].push_back(e[2]); refresh(); end
      tick();
      if (c >= 4 && c <= 9) begin
        tests++; if (s_grant !== 5'b00100 || s_rd !== 5'b0) begin fails++; $display("FAIL stall c=%0d grant=%b rd=%b exp=00100/00000", c, s_grant, s_rd); end
      end
    end
    tests++; if (got.size() != 4) begin fails++; $display("FAIL stall_count got=%0d exp=4", got.size()); end
    for (int k = 0; k < got.size() && k < 4; k++) begin
      tests++; if (got[k] !== e[k]) begin fails++; $display("FAIL stall_data k=%0d got=%h exp=%h", k, got[k], e[k]); end
    end
    tests++; if (gseen.size() != 2 || gseen[0] != 2 || gseen[1] != 0) begin fails++; $display("FAIL stall_order n=%0d exp=2,0", gseen.size()); end
  endtask

  task automatic test_reset_mid_packet();
    logic [DW-1:0] e [5];
    int order [3];
    order = '{0, 1, 4};
    e = '{mk(1'b1, 1'b1, 16'h0100), mk(1'b1, 1'b0, 16'h1100), mk(1'b1, 1'b1, 16'h1101),
          mk(1'b0, 1'b0, 16'h4002), mk(1'b0, 1'b1, 16'h4003)};
    do_reset();
    fq[4].push_back(mk(1'b1, 1'b0, 16'h4001)); fq[4].push_back(e[3]); fq[4].push_back(e[4]);
    refresh();
    bus.req = 5'b10000;
    tick(); tick();
    rst = 1'b1;
    tick();
    tests++; if (s_wr !== 1'b1) begin fails++; $display("FAIL rstmid_in_wait got=%b exp=1", s_wr); end
    rst = 1'b0;
    fq[0].push_back(e[0]); fq[1].push_back(e[1]); fq[1].push_back(e[2]);
    bus.req = 5'b10011;
    refresh();
    tick();
    tests++; if (s_grant !== 5'b0 || s_busy !== 1'b0 || s_rd !== 5'b0) begin fails++; $display("FAIL rstmid_state grant=%b busy=%b rd=%b exp=0", s_grant, s_busy, s_rd); end
    tests++; if (s_wr !== 1'b0 || s_wdata !== '0 || s_perr !== 1'b0) begin fails++; $display("FAIL rstmid_out wr=%b data=%h perr=%b exp=0", s_wr, s_wdata, s_perr); end
    clear_mon();
    repeat (24) tick();
    tests++; if (got.size() != 5) begin fails++; $display("FAIL rstmid_count got=%0d exp=5", got.size()); end
    for (int k = 0; k < got.size() && k < 5; k++) begin
      tests++; if (got[k] !== e[k]) begin fails++; $display("FAIL rstmid_data k=%0d got=%h exp=%h", k, got[k], e[k]); end
    end
    for (int k = 0; k < 3; k++) begin
      tests++; if (k >= gseen.size() || gseen[k] != order[k]) begin fails++; $display("FAIL rstmid_order k=%0d seen=%0d exp=%0d", k, (k < gseen.size()) ? gseen[k] : -1, order[k]); end
    end
    tests++; if (proto_cnt != 2) begin fails++; $display("FAIL proto_err_pulses got=%0d exp=2", proto_cnt); end
  endtask

  task automatic test_random();
    bit to;
    for (int it = 0; it < 6; it++) begin
      do_reset();
      req_mask = N'($urandom_range(1, 31));
      for (int i = 0; i < N; i++) begin
        int np;
        np = $urandom_range(0, 3);
        for (int p = 0; p < np; p++) load_pkt(i, $urandom_range(1, 4));
      end
      load_pkt(idx_of(req_mask), $urandom_range(1, 4));
      build_expected();
      run_collect(30, to);
      tests++; if (to || got.size() != exp_flits.size()) begin fails++; $display("FAIL rand%0d_count got=%0d exp=%0d", it, got.size(), exp_flits.size()); end
      for (int k = 0; k < got.size() && k < exp_flits.size(); k++) begin
        tests++; if (got[k] !== exp_flits[k]) begin fails++; $display("FAIL rand%0d_data k=%0d got=%h exp=%h", it, k, got[k], exp_flits[k]); end
      end
      tests++; if (gseen != exp_grants) begin fails++; $display("FAIL rand%0d_order grants=%0d exp=%0d", it, gseen.size(), exp_grants.size()); end
      tests++; if (viol != 0 || proto_cnt != 0) begin fails++; $display("FAIL rand%0d_invariants viol=%0d perr=%0d exp=0/0", it, viol, proto_cnt); end
      tests++; if (s_grant !== 5'b0 || s_busy !== 1'b0) begin fails++; $display("FAIL rand%0d_idle grant=%b busy=%b exp=0", it, s_grant, s_busy); end
    end
  endtask

  initial begin
    test_reset();
    test_single_packet();
    test_round_robin_all();
    test_back_to_back();
    test_backpressure();
    test_empty_stall();
    test_reset_mid_packet();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired tests=%0d failed=%0d", tests, fails);
    $fatal(1);
  end

endmodule
